// File: rtl/branch_pkg.sv
// Shared definitions for the branch prediction controller: 2-bit counter
// encodings, the redirect-source selector and the saturating counter step.
package branch_pkg;

    localparam logic [1:0] BHT_SNT = 2'd0;
    localparam logic [1:0] BHT_WNT = 2'd1;
    localparam logic [1:0] BHT_WT  = 2'd2;
    localparam logic [1:0] BHT_ST  = 2'd3;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_ID   = 2'd1,
        RD_EX   = 2'd2
    } rd_src_e;

    // Move a 2-bit counter one step toward ST (taken) or SNT (not taken),
    // holding at the end points.
    function automatic logic [1:0] bht_sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != BHT_ST) begin
                res = cnt + 2'd1;
            end
        end else begin
            if (cnt != BHT_SNT) begin
                res = cnt - 2'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating counters: two asynchronous read ports (ID lookup
// and EX read-modify-write) and one synchronous write port.
module branch_history_table
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_cnt,
    input  logic [IDX_W-1:0] i_ex_idx,
    output logic [1:0]       o_ex_cnt,
    input  logic             i_wr_en,
    input  logic [1:0]       i_wr_cnt
);

    logic [1:0] r_bht [ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            // Each counter resets to weakly-not-taken and is written only by
            // a resolve that targets its own index.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_bht[gi] <= BHT_WNT;
                end else if (i_wr_en && (i_ex_idx == IDX_W'(gi))) begin
                    r_bht[gi] <= i_wr_cnt;
                end
            end
        end
    endgenerate

    // Reads see the stored value only; a same-cycle write is not bypassed.
    assign o_rd_cnt = r_bht[i_rd_idx];
    assign o_ex_cnt = r_bht[i_ex_idx];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predict/resolve controller: predicts ID branches from the counter
// table, detects EX mispredictions, picks the redirect source and keeps
// branch / mispredict statistics.
module branch_predict_ctrl
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int XLEN        = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_id_valid,
    input  logic            i_id_is_branch,
    input  logic [XLEN-1:0] i_id_pc,
    input  logic [XLEN-1:0] i_id_target,
    output logic            o_pred_taken,
    input  logic            i_ex_valid,
    input  logic            i_ex_is_branch,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic            i_ex_take,
    input  logic            i_ex_pred_taken,
    input  logic [XLEN-1:0] i_ex_target,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_flush_ifid,
    output logic            o_flush_idex,
    output logic [31:0]     o_branch_count,
    output logic [31:0]     o_mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0] w_id_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic [1:0]       w_id_cnt;
    logic [1:0]       w_ex_cnt;
    logic [1:0]       w_ex_cnt_next;
    logic             w_resolve;
    logic             w_mispredict;
    logic             w_id_pred;
    rd_src_e          w_rd_src;
    logic [31:0]      r_branch_count;
    logic [31:0]      r_mispredict_count;
    logic             w_unused_pc_bits;

    // Word-aligned PCs: the low two bits never take part in indexing.
    assign w_id_idx = i_id_pc[IDX_W+1:2];
    assign w_ex_idx = i_ex_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^{i_id_pc[XLEN-1:IDX_W+2], i_id_pc[1:0],
                                i_ex_pc[1:0]};

    assign w_resolve     = i_ex_valid & i_ex_is_branch;
    assign w_mispredict  = w_resolve & (i_ex_take ^ i_ex_pred_taken);
    assign w_id_pred     = i_id_valid & i_id_is_branch & w_id_cnt[1];
    assign w_ex_cnt_next = bht_sat_update(w_ex_cnt, i_ex_take);

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_rd_idx (w_id_idx),
        .o_rd_cnt (w_id_cnt),
        .i_ex_idx (w_ex_idx),
        .o_ex_cnt (w_ex_cnt),
        .i_wr_en  (w_resolve),
        .i_wr_cnt (w_ex_cnt_next)
    );

    // Redirect source: an EX mispredict wins because the ID instruction that
    // made the competing prediction is on the wrong path and gets flushed.
    always_comb begin
        w_rd_src = RD_NONE;
        if (!i_rst_n) begin
            w_rd_src = RD_NONE;
        end else if (w_mispredict) begin
            w_rd_src = RD_EX;
        end else if (w_id_pred) begin
            w_rd_src = RD_ID;
        end
    end

    // Redirect target and flush controls from the selected source; all quiet
    // while reset is held.
    always_comb begin
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;
        o_flush_ifid     = 1'b0;
        o_flush_idex     = 1'b0;
        case (w_rd_src)
            RD_EX: begin
                o_redirect_valid = 1'b1;
                o_redirect_pc    = i_ex_take ? i_ex_target : (i_ex_pc + XLEN'(4));
                o_flush_ifid     = 1'b1;
                o_flush_idex     = 1'b1;
            end
            RD_ID: begin
                o_redirect_valid = 1'b1;
                o_redirect_pc    = i_id_target;
                o_flush_ifid     = 1'b1;
            end
            default: begin
                o_redirect_valid = 1'b0;
            end
        endcase
    end

    assign o_pred_taken = i_rst_n & w_id_pred;

    // Statistics: one count per resolve / per mispredict, saturating at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_resolve && (r_branch_count != 32'hFFFF_FFFF)) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (w_mispredict && (r_mispredict_count != 32'hFFFF_FFFF)) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign o_branch_count     = r_branch_count;
    assign o_mispredict_count = r_mispredict_count;

endmodule
